// File: rtl/mips_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the MIPS arithmetic datapath, with trap/HALT.
// Optional macro SEQ_PERF_CNT_EN adds free-running cycle and retired-instruction counters.
//
// state  | meaning
// FETCH  | offer inst_ready, wait for inst_valid handshake
// DECODE | IR stable; trap on dec_except, else load EXEC counter
// EXEC   | ALU busy for EXEC_CYCLES cycles
// WB     | register write (if enabled), retire, advance pc
// HALT   | trapped; wait for exc_ack, then skip faulting instruction
module mips_seq_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter logic [31:0] RESET_PC    = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_valid,
    output logic        inst_ready,
    output logic        ir_load,
    input  logic        dec_except,
    input  logic        dec_writeenable,
    input  logic        exc_ack,
    output logic        alu_en,
    output logic        rf_we,
    output logic        retire,
    output logic        except,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [2:0]  state
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [3:0]  exec_cnt_q, exec_cnt_d;

    logic inst_ready_c, ir_load_c, alu_en_c, rf_we_c, retire_c, except_c;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epc_d        = epc_q;
        exec_cnt_d   = exec_cnt_q;
        inst_ready_c = 1'b0;
        ir_load_c    = 1'b0;
        alu_en_c     = 1'b0;
        rf_we_c      = 1'b0;
        retire_c     = 1'b0;
        except_c     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                inst_ready_c = 1'b1;
                if (inst_valid) begin
                    ir_load_c = 1'b1;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_except) begin
                    epc_d   = pc_q;
                    state_d = ST_HALT;
                end else begin
                    exec_cnt_d = EXEC_LOAD;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_en_c = 1'b1;
                if (exec_cnt_q == 4'd0) begin
                    state_d = ST_WB;
                end else begin
                    exec_cnt_d = exec_cnt_q - 4'd1;
                end
            end
            ST_WB: begin
                rf_we_c  = dec_writeenable;
                retire_c = 1'b1;
                pc_d     = pc_q + 32'd4;
                state_d  = ST_FETCH;
            end
            ST_HALT: begin
                except_c = 1'b1;
                if (exc_ack) begin
                    // Resume past the faulting instruction; a trap never retires.
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            epc_q      <= 32'd0;
            exec_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            exec_cnt_q <= exec_cnt_d;
        end
    end

    // Reset wins over a state that happens to be WB/EXEC in the same cycle.
    assign inst_ready = inst_ready_c & ~reset;
    assign ir_load    = ir_load_c    & ~reset;
    assign alu_en     = alu_en_c     & ~reset;
    assign rf_we      = rf_we_c      & ~reset;
    assign retire     = retire_c     & ~reset;
    assign except     = except_c     & ~reset;

    assign pc    = pc_q;
    assign epc   = epc_q;
    assign state = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + 32'd1;
        retired_cnt_d = retired_cnt_q;
        if (retire_c) begin
            retired_cnt_d = retired_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q   <= 32'd0;
            retired_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Directed bench for mips_seq_ctrl: instance a (EXEC_CYCLES=1, default RESET_PC),
// instance b (EXEC_CYCLES=3, RESET_PC near wrap).
module tb_mips_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_reset, a_inst_valid, a_dec_except, a_dec_we, a_exc_ack;
    logic        a_inst_ready, a_ir_load, a_alu_en, a_rf_we, a_retire, a_except;
    logic [31:0] a_pc, a_epc;
    logic [2:0]  a_state;

    logic        b_reset, b_inst_valid, b_dec_except, b_dec_we, b_exc_ack;
    logic        b_inst_ready, b_ir_load, b_alu_en, b_rf_we, b_retire, b_except;
    logic [31:0] b_pc, b_epc;
    logic [2:0]  b_state;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] a_cycle_cnt, a_retired_cnt, b_cycle_cnt, b_retired_cnt;
`endif

    mips_seq_ctrl #(.EXEC_CYCLES(1), .RESET_PC(32'h0040_0000)) dut_a (
        .clk(clk), .reset(a_reset), .inst_valid(a_inst_valid), .inst_ready(a_inst_ready),
        .ir_load(a_ir_load), .dec_except(a_dec_except), .dec_writeenable(a_dec_we),
        .exc_ack(a_exc_ack), .alu_en(a_alu_en), .rf_we(a_rf_we), .retire(a_retire),
        .except(a_except), .pc(a_pc), .epc(a_epc), .state(a_state)
`ifdef SEQ_PERF_CNT_EN
        , .cycle_cnt(a_cycle_cnt), .retired_cnt(a_retired_cnt)
`endif
    );

    mips_seq_ctrl #(.EXEC_CYCLES(3), .RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .reset(b_reset), .inst_valid(b_inst_valid), .inst_ready(b_inst_ready),
        .ir_load(b_ir_load), .dec_except(b_dec_except), .dec_writeenable(b_dec_we),
        .exc_ack(b_exc_ack), .alu_en(b_alu_en), .rf_we(b_rf_we), .retire(b_retire),
        .except(b_except), .pc(b_pc), .epc(b_epc), .state(b_state)
`ifdef SEQ_PERF_CNT_EN
        , .cycle_cnt(b_cycle_cnt), .retired_cnt(b_retired_cnt)
`endif
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        a_reset = 1'b1; a_inst_valid = 1'b0; a_dec_except = 1'b0; a_dec_we = 1'b0; a_exc_ack = 1'b0;
        b_reset = 1'b1; b_inst_valid = 1'b0; b_dec_except = 1'b0; b_dec_we = 1'b0; b_exc_ack = 1'b0;

        // Reset state
        smp();
        chk32("rst_state", 32'(a_state), 32'd0);
        chk32("rst_pc", a_pc, 32'h0040_0000);
        chk32("rst_epc", a_epc, 32'd0);
        chk1("rst_rf_we", a_rf_we, 1'b0);
        chk1("rst_retire", a_retire, 1'b0);
        chk32("rst_b_pc", b_pc, 32'hFFFF_FFFC);
        cyc();

        // Back-to-back instructions, EXEC_CYCLES=1: retire every 4 cycles
        a_reset = 1'b0; a_inst_valid = 1'b1; a_dec_we = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                smp();
                chk32("t1_state", 32'(a_state), 32'(j));
                chk32("t1_pc", a_pc, 32'h0040_0000 + 32'(4 * i));
                chk1("t1_ir_load", a_ir_load, j == 0);
                chk1("t1_alu_en", a_alu_en, j == 2);
                chk1("t1_rf_we", a_rf_we, j == 3);
                chk1("t1_retire", a_retire, j == 3);
                cyc();
            end
        end

        // Trap on the third instruction
        smp();
        chk32("t3_fetch_state", 32'(a_state), 32'd0);
        chk32("t3_fetch_pc", a_pc, 32'h0040_0008);
        cyc();
        a_dec_except = 1'b1;
        smp();
        chk32("t3_decode_state", 32'(a_state), 32'd1);
        cyc();
        a_dec_except = 1'b0;
        smp();
        chk32("t3_halt_state", 32'(a_state), 32'd4);
        chk1("t3_except", a_except, 1'b1);
        chk32("t3_epc", a_epc, 32'h0040_0008);
        chk32("t3_halt_pc", a_pc, 32'h0040_0008);
        chk1("t3_rf_we", a_rf_we, 1'b0);
        chk1("t3_retire", a_retire, 1'b0);
        chk1("t3_inst_ready", a_inst_ready, 1'b0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            smp();
            chk32("t3_hold_state", 32'(a_state), 32'd4);
            chk1("t3_hold_except", a_except, 1'b1);
            cyc();
        end
        a_exc_ack = 1'b1;
        smp();
        chk1("t3_ack_retire", a_retire, 1'b0);
        chk32("t3_ack_state", 32'(a_state), 32'd4);
        cyc();
        a_exc_ack = 1'b0;
        smp();
        chk32("t3_resume_state", 32'(a_state), 32'd0);
        chk32("t3_resume_pc", a_pc, 32'h0040_000C);
        chk1("t3_resume_except", a_except, 1'b0);
        chk32("t3_resume_epc", a_epc, 32'h0040_0008);
        cyc();

        // Reset while in EXEC
        smp();
        chk32("t4_decode_state", 32'(a_state), 32'd1);
        cyc();
        a_reset = 1'b1;
        smp();
        chk32("t4_exec_state", 32'(a_state), 32'd2);
        chk1("t4_exec_rf_we", a_rf_we, 1'b0);
        chk1("t4_exec_retire", a_retire, 1'b0);
        cyc();
        a_reset = 1'b0; a_inst_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk32("t4_state", 32'(a_state), 32'd0);
            chk32("t4_pc", a_pc, 32'h0040_0000);
            chk32("t4_epc", a_epc, 32'd0);
            chk1("t4_retire", a_retire, 1'b0);
            chk1("t4_rf_we", a_rf_we, 1'b0);
            chk1("t4_ir_load", a_ir_load, 1'b0);
            chk1("t4_inst_ready", a_inst_ready, 1'b1);
            cyc();
        end

`ifdef SEQ_PERF_CNT_EN
        // Performance counters: 10 instructions in 40 cycles
        a_reset = 1'b1;
        smp();
        cyc();
        a_reset = 1'b0; a_inst_valid = 1'b1; a_dec_we = 1'b1;
        smp();
        chk32("t6_cycle_start", a_cycle_cnt, 32'd0);
        chk32("t6_retired_start", a_retired_cnt, 32'd0);
        cyc();
        repeat (39) cyc();
        smp();
        chk32("t6_retired_cnt", a_retired_cnt, 32'd10);
        chk32("t6_cycle_cnt", a_cycle_cnt, 32'd40);
        chk32("t6_pc", a_pc, 32'h0040_0028);
        cyc();
        a_inst_valid = 1'b0;
`endif

        // EXEC_CYCLES=3 latency and pc wrap
        b_reset = 1'b0; b_inst_valid = 1'b1; b_dec_we = 1'b1;
        smp();
        chk32("t2_fetch_state", 32'(b_state), 32'd0);
        chk32("t2_fetch_pc", b_pc, 32'hFFFF_FFFC);
        chk1("t2_ir_load", b_ir_load, 1'b1);
        cyc();
        b_inst_valid = 1'b0;
        smp();
        chk32("t2_decode_state", 32'(b_state), 32'd1);
        chk1("t2_decode_alu_en", b_alu_en, 1'b0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            smp();
            chk32("t2_exec_state", 32'(b_state), 32'd2);
            chk1("t2_exec_alu_en", b_alu_en, 1'b1);
            chk1("t2_exec_rf_we", b_rf_we, 1'b0);
            chk1("t2_exec_retire", b_retire, 1'b0);
            cyc();
        end
        smp();
        chk32("t2_wb_state", 32'(b_state), 32'd3);
        chk1("t2_wb_rf_we", b_rf_we, 1'b1);
        chk1("t2_wb_retire", b_retire, 1'b1);
        chk1("t2_wb_alu_en", b_alu_en, 1'b0);
        cyc();
        for (int k = 0; k < 2; k++) begin
            smp();
            chk32("t5_idle_state", 32'(b_state), 32'd0);
            chk32("t5_wrap_pc", b_pc, 32'd0);
            chk1("t5_idle_ir_load", b_ir_load, 1'b0);
            chk1("t5_idle_inst_ready", b_inst_ready, 1'b1);
            cyc();
        end

        // Instruction without register write still retires
        b_inst_valid = 1'b1; b_dec_we = 1'b0;
        smp();
        chk1("t5_ir_load", b_ir_load, 1'b1);
        cyc();
        b_inst_valid = 1'b0;
        repeat (4) cyc();
        smp();
        chk32("t5_wb_state", 32'(b_state), 32'd3);
        chk1("t5_wb_rf_we", b_rf_we, 1'b0);
        chk1("t5_wb_retire", b_retire, 1'b1);
        cyc();
        smp();
        chk32("t5_next_pc", b_pc, 32'd4);
        chk32("t5_epc", b_epc, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
